// File: rtl/cpu_pkg.sv
// Package shared by the fetch and decode stages: reset vector, NOP word,
// decode redirect encodings and the common 32-bit word type.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC = 32'hBFC0_0000;
  localparam word_t INST_NOP = 32'h0000_0000;

  // Redirect kind driven by decode on C1
  typedef enum logic [1:0] {
    C1_NONE = 2'b00,  // sequential fetch
    C1_BR   = 2'b01,  // PC-relative branch taken (jmpAddr = offset<<2)
    C1_J    = 2'b10,  // J/JAL region jump (jmpAddr absolute)
    C1_JR   = 2'b11   // register jump (jmpAddr absolute)
  } c1_e;

  // A fetch address is word aligned when its two low bits are zero
  function automatic logic is_misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of signals between fetch, decode and the instruction SRAM.
// Optional FETCH_ADEL_CHECK_EN adds the address-error flag and the
// captured misaligned fetch address.
interface fetch_stage_if;
  import cpu_pkg::*;

  // decode -> fetch
  logic        allowIN;
  logic [1:0]  C1;
  word_t       jmpAddr;
  word_t       id_pc;
  // fetch <-> instruction SRAM
  logic        inst_sram_en;
  word_t       inst_sram_addr;
  word_t       inst_sram_rdata;
  // fetch -> decode
  word_t       PC;
  word_t       instruction;
  logic        fs_valid;
`ifdef FETCH_ADEL_CHECK_EN
  logic        adel;
  word_t       badvaddr;
`endif

  // Fetch stage side
  modport master (
    input  allowIN, C1, jmpAddr, id_pc, inst_sram_rdata,
`ifdef FETCH_ADEL_CHECK_EN
    output adel, badvaddr,
`endif
    output inst_sram_en, inst_sram_addr, PC, instruction, fs_valid
  );

  // Decode / SRAM side
  modport slave (
    output allowIN, C1, jmpAddr, id_pc, inst_sram_rdata,
`ifdef FETCH_ADEL_CHECK_EN
    input  adel, badvaddr,
`endif
    input  inst_sram_en, inst_sram_addr, PC, instruction, fs_valid
  );

endinterface

// File: rtl/fetch_stage_next_pc_gen.sv
// Combinational next-PC selection from the current fetch PC and the
// redirect request coming back from decode. All sums wrap mod 2^32.
module next_pc_gen
  import cpu_pkg::*;
(
  input  word_t       fs_pc,
  input  word_t       id_pc,
  input  logic [1:0]  C1,
  input  word_t       jmpAddr,
  output word_t       next_pc
);

  // Pick sequential, branch-relative or absolute target
  always_comb begin
    next_pc = fs_pc + 32'd4;
    case (c1_e'(C1))
      C1_NONE: next_pc = fs_pc + 32'd4;
      // Branch is relative to the delay slot, i.e. the branch PC + 4
      C1_BR:   next_pc = id_pc + 32'd4 + jmpAddr;
      C1_J:    next_pc = jmpAddr;
      C1_JR:   next_pc = jmpAddr;
      default: next_pc = fs_pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous
// instruction SRAM and buffers read data while decode is stalled.
// Optional macro FETCH_ADEL_CHECK_EN enables misaligned-fetch detection.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] INST_NOP = cpu_pkg::INST_NOP
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active low
  fetch_stage_if.master  bus
);
  import cpu_pkg::*;

  word_t fs_pc_reg;
  logic  fs_valid_reg;
  word_t hold_buf_reg;
  logic  hold_valid_reg;
  word_t next_pc;
  logic  next_bad;

  next_pc_gen u_next_pc_gen (
    .fs_pc   (fs_pc_reg),
    .id_pc   (bus.id_pc),
    .C1      (bus.C1),
    .jmpAddr (bus.jmpAddr),
    .next_pc (next_pc)
  );

`ifdef FETCH_ADEL_CHECK_EN
  logic  adel_reg;
  word_t badvaddr_reg;
  assign next_bad = is_misaligned(next_pc);
`else
  assign next_bad = 1'b0;
`endif

  // A read is issued only when decode accepts, out of reset, and the
  // target is usable; a misaligned target never reaches the SRAM.
  assign bus.inst_sram_en   = bus.allowIN & rst & ~next_bad;
  assign bus.inst_sram_addr = next_pc;
  assign bus.PC             = fs_pc_reg;
  assign bus.fs_valid       = fs_valid_reg;

`ifdef FETCH_ADEL_CHECK_EN
  assign bus.adel     = adel_reg;
  assign bus.badvaddr = badvaddr_reg;
`endif

  // Decode sees NOP when empty, the held word after a stall, else live SRAM data
  always_comb begin
    bus.instruction = bus.inst_sram_rdata;
    if (!fs_valid_reg) begin
      bus.instruction = INST_NOP;
`ifdef FETCH_ADEL_CHECK_EN
    end else if (adel_reg) begin
      bus.instruction = INST_NOP;
`endif
    end else if (hold_valid_reg) begin
      bus.instruction = hold_buf_reg;
    end
  end

  // Stage registers: advance on allowIN, otherwise capture SRAM data once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fs_pc_reg      <= RESET_PC - 32'd4;
      fs_valid_reg   <= 1'b0;
      hold_buf_reg   <= '0;
      hold_valid_reg <= 1'b0;
    end else if (bus.allowIN) begin
      fs_pc_reg      <= next_pc;
      fs_valid_reg   <= 1'b1;
      hold_valid_reg <= 1'b0;
    end else if (!hold_valid_reg) begin
      // Read data is only valid the cycle after the read; keep it for decode
      hold_buf_reg   <= bus.inst_sram_rdata;
      hold_valid_reg <= 1'b1;
    end
  end

`ifdef FETCH_ADEL_CHECK_EN
  // Address-error flag and faulting address, updated on every advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adel_reg     <= 1'b0;
      badvaddr_reg <= '0;
    end else if (bus.allowIN) begin
      adel_reg <= next_bad;
      if (next_bad) begin
        badvaddr_reg <= next_pc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, all checked against a behavioural fetch model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: the instruction that decode should currently be seeing
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_adel;

  // Values seen on the DUT during the most recent step
  logic [31:0] obs_pc, obs_inst, obs_addr;
  logic        obs_valid, obs_en, obs_adel;

  // SRAM model: word at address A is A>>2; data is only meaningful the
  // cycle after an enabled read, otherwise it is garbage.
  always @(posedge clk) begin
    if (bus.inst_sram_en) bus.inst_sram_rdata <= bus.inst_sram_addr >> 2;
    else                  bus.inst_sram_rdata <= $urandom;
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presented instruction follows from the presented PC, since memory is A>>2
  function automatic logic [31:0] model_inst();
    if (!m_valid || m_adel) return 32'h0;
    return m_pc >> 2;
  endfunction

  // Redirect rules expressed directly from the decode encodings
  function automatic logic [31:0] model_target(input logic [1:0] c1, input logic [31:0] jmp,
                                               input logic [31:0] idpc);
    if (c1 == 2'b01) return idpc + 32'd4 + jmp;
    if (c1 == 2'b00) return m_pc + 32'd4;
    return jmp;
  endfunction

  // One clock cycle: drive decode inputs, check, then let the edge happen
  task automatic step(input logic allow, input logic [1:0] c1, input logic [31:0] jmp,
                      input logic [31:0] idpc);
    logic [31:0] tgt;
    logic        bad;
    @(negedge clk);
    bus.allowIN = allow;
    bus.C1      = c1;
    bus.jmpAddr = jmp;
    bus.id_pc   = idpc;
    #1;
    tgt = model_target(c1, jmp, idpc);
`ifdef FETCH_ADEL_CHECK_EN
    bad = (tgt[1:0] != 2'b00);
    obs_adel = bus.adel;
    check32("adel", 32'(bus.adel), 32'(m_adel));
`else
    bad = 1'b0;
    obs_adel = 1'b0;
`endif
    obs_pc    = bus.PC;
    obs_inst  = bus.instruction;
    obs_valid = bus.fs_valid;
    obs_en    = bus.inst_sram_en;
    obs_addr  = bus.inst_sram_addr;
    check32("pc", bus.PC, m_pc);
    check32("inst", bus.instruction, model_inst());
    check32("valid", 32'(bus.fs_valid), 32'(m_valid));
    check32("en", 32'(bus.inst_sram_en), 32'(allow && !bad));
    if (allow && !bad) check32("addr", bus.inst_sram_addr, tgt);
    @(posedge clk);
    if (allow) begin
      m_pc    = tgt;
      m_valid = 1'b1;
      m_adel  = bad;
    end
    $display("cycle allow=%0d C1=%0d jmp=%h id_pc=%h -> pc=%h inst=%h valid=%0d en=%0d addr=%h",
             allow, c1, jmp, idpc, obs_pc, obs_inst, obs_valid, obs_en, obs_addr);
  endtask

  // Assert reset asynchronously mid-cycle, check reset outputs, release
  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.allowIN = 1'b0;
    bus.C1 = 2'b00;
    #1;
    m_pc    = RESET_PC - 32'd4;
    m_valid = 1'b0;
    m_adel  = 1'b0;
    check32("rst_pc", bus.PC, 32'hBFBF_FFFC);
    check32("rst_inst", bus.instruction, 32'h0);
    check32("rst_valid", 32'(bus.fs_valid), 32'h0);
    check32("rst_en", 32'(bus.inst_sram_en), 32'h0);
    $display("reset asserted pc=%h inst=%h valid=%0d", bus.PC, bus.instruction, bus.fs_valid);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       allow;
    logic [1:0] c1;
    bus.allowIN = 1'b0;
    bus.C1      = 2'b00;
    bus.jmpAddr = '0;
    bus.id_pc   = '0;
    m_pc = RESET_PC - 32'd4; m_valid = 1'b0; m_adel = 1'b0;

    apply_reset();

    // First fetch after reset and its one-cycle latency
    step(1'b1, 2'b00, 32'h0, 32'h0);
    check32("first_addr", obs_addr, 32'hBFC0_0000);
    check32("first_en", 32'(obs_en), 32'h1);
    step(1'b1, 2'b00, 32'h0, 32'h0);
    check32("c1_pc", obs_pc, 32'hBFC0_0000);
    check32("c1_inst", obs_inst, 32'h2FF0_0000);
    check32("c1_valid", 32'(obs_valid), 32'h1);
    step(1'b1, 2'b00, 32'h0, 32'h0);
    check32("c2_pc", obs_pc, 32'hBFC0_0004);

    // Three-cycle stall at BFC00008 with randomised SRAM output
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 32'h0, 32'h0);
      check32("stall_inst", obs_inst, 32'h2FF0_0002);
      check32("stall_en", 32'(obs_en), 32'h0);
    end
    step(1'b1, 2'b00, 32'h0, 32'h0);
    check32("release_addr", obs_addr, 32'hBFC0_000C);
    step(1'b1, 2'b00, 32'h0, 32'h0);
    step(1'b1, 2'b00, 32'h0, 32'h0);

    // Backward branch with delay slot still presented
    step(1'b1, 2'b01, 32'hFFFF_FFF0, 32'hBFC0_0010);
    check32("slot_pc", obs_pc, 32'hBFC0_0014);
    check32("br_addr", obs_addr, 32'hBFC0_0004);
    step(1'b1, 2'b10, 32'hBFC0_0100, 32'hBFC0_0000);
    check32("br_land", obs_pc, 32'hBFC0_0004);
    check32("j_addr", obs_addr, 32'hBFC0_0100);
    step(1'b1, 2'b11, 32'h8000_0000, 32'hBFC0_0004);
    check32("jr_addr", obs_addr, 32'h8000_0000);
    step(1'b1, 2'b00, 32'h0, 32'h0);
    check32("jr_land", obs_pc, 32'h8000_0000);
    check32("jr_inst", obs_inst, 32'h2000_0000);

`ifdef FETCH_ADEL_CHECK_EN
    // Misaligned register jump: no read, address error flagged next cycle
    step(1'b1, 2'b11, 32'h8000_0002, 32'h8000_0000);
    check32("adel_en", 32'(obs_en), 32'h0);
    step(1'b1, 2'b10, 32'h8000_0010, 32'h8000_0000);
    check32("adel_flag", 32'(obs_adel), 32'h1);
    check32("adel_inst", obs_inst, 32'h0);
    check32("adel_valid", 32'(obs_valid), 32'h1);
    check32("adel_bad", bus.badvaddr, 32'h8000_0002);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    check32("adel_clear", 32'(obs_adel), 32'h0);
`endif

    // Reset in the middle of a stall with the hold buffer occupied
    step(1'b0, 2'b00, 32'h0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    apply_reset();
    step(1'b1, 2'b00, 32'h0, 32'h0);
    check32("refetch_addr", obs_addr, 32'hBFC0_0000);

    // Stall straight out of reset: nothing fetched, nothing valid
    apply_reset();
    step(1'b0, 2'b00, 32'h0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    check32("idle_valid", 32'(obs_valid), 32'h0);
    check32("idle_en", 32'(obs_en), 32'h0);
    step(1'b1, 2'b00, 32'h0, 32'h0);
    step(1'b1, 2'b00, 32'h0, 32'h0);
    check32("idle_first", obs_pc, 32'hBFC0_0000);

    // Randomized traffic with word-aligned redirect operands
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) apply_reset();
      allow = ($urandom_range(0, 3) != 0);
      c1    = allow ? 2'($urandom_range(0, 3)) : 2'b00;
      step(allow, c1, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
